// File: rtl/reversi_move_scanner.sv
// Reversi move scanner: for a target cell, walks all eight directions one cell
// per clock and reports which directions capture, where each capture ends, and
// how many opponent pieces would flip in total.
module reversi_move_scanner #(
  parameter int unsigned BOARD_DIM = 8,
  localparam int unsigned CW  = $clog2(BOARD_DIM),
  localparam int unsigned EPW = 2 * CW,
  localparam int unsigned FW  = $clog2(8 * BOARD_DIM),
  localparam int unsigned NB  = 2 * BOARD_DIM * BOARD_DIM
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [CW-1:0]      x,
  input  logic [CW-1:0]      y,
  input  logic               player_black,
  input  logic [NB-1:0]      board,
  output logic               busy,
  output logic               done,
  output logic [7:0]         valids,
  output logic [8*EPW-1:0]   end_points,
  output logic [FW-1:0]      flip_total
);

  localparam int unsigned IW = 2 * CW;
  localparam logic [CW:0] BDW = (CW+1)'(BOARD_DIM);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     x_q, x_n, y_q, y_n;
  logic              black_q, black_n;
  logic [NB-1:0]     board_q, board_n;
  logic [2:0]        dir, dir_n;
  logic [CW-1:0]     cx, cx_n, cy, cy_n;
  logic [CW-1:0]     run, run_n;
  logic              busy_n, done_n;
  logic [7:0]        valids_n;
  logic [8*EPW-1:0]  end_points_n;
  logic [FW-1:0]     flip_total_n;

  logic [CW:0]       sx, sy;
  logic              off, term;
  logic [1:0]        scell, tcell, own_c, opp_c;

  // Cell (cx,cy) of a flattened board; caller guarantees coordinates in range.
  function automatic logic [1:0] cell_at(input logic [NB-1:0] b,
                                         input logic [CW-1:0] px,
                                         input logic [CW-1:0] py);
    logic [IW-1:0] idx;
    idx = IW'(py) * IW'(BOARD_DIM) + IW'(px);
    return b[{idx, 1'b0} +: 2];
  endfunction

  // One step in x for direction d; one extra bit so -1 and BOARD_DIM both read as off-board.
  function automatic logic [CW:0] step_x(input logic [2:0] d, input logic [CW-1:0] c);
    case (d)
      3'd1, 3'd2, 3'd3: return {1'b0, c} + (CW+1)'(1);
      3'd5, 3'd6, 3'd7: return {1'b0, c} - (CW+1)'(1);
      default:          return {1'b0, c};
    endcase
  endfunction

  // One step in y for direction d (y grows downward).
  function automatic logic [CW:0] step_y(input logic [2:0] d, input logic [CW-1:0] c);
    case (d)
      3'd0, 3'd1, 3'd7: return {1'b0, c} - (CW+1)'(1);
      3'd3, 3'd4, 3'd5: return {1'b0, c} + (CW+1)'(1);
      default:          return {1'b0, c};
    endcase
  endfunction

  // Next-state and datapath: one examined cell per SCAN cycle.
  always_comb begin
    state_n      = state;
    x_n          = x_q;
    y_n          = y_q;
    black_n      = black_q;
    board_n      = board_q;
    dir_n        = dir;
    cx_n         = cx;
    cy_n         = cy;
    run_n        = run;
    valids_n     = valids;
    end_points_n = end_points;
    flip_total_n = flip_total;
    term         = 1'b0;

    sx    = step_x(dir, cx);
    sy    = step_y(dir, cy);
    off   = (sx >= BDW) || (sy >= BDW);
    scell = cell_at(board_q, sx[CW-1:0], sy[CW-1:0]);
    tcell = cell_at(board_q, x_q, y_q);
    own_c = black_q ? 2'b01 : 2'b10;
    opp_c = black_q ? 2'b10 : 2'b01;

    case (state)
      IDLE: begin
        if (start) begin
          x_n          = x;
          y_n          = y;
          black_n      = player_black;
          board_n      = board;
          dir_n        = '0;
          run_n        = '0;
          valids_n     = '0;
          end_points_n = '0;
          flip_total_n = '0;
          state_n      = CHECK;
        end
      end
      CHECK: begin
        if (({1'b0, x_q} >= BDW) || ({1'b0, y_q} >= BDW) ||
            (tcell == 2'b01) || (tcell == 2'b10)) begin
          state_n = DONE;
        end else begin
          state_n = SCAN;
          dir_n   = '0;
          cx_n    = x_q;
          cy_n    = y_q;
          run_n   = '0;
        end
      end
      SCAN: begin
        if (off || (scell == 2'b00) || (scell == 2'b11)) begin
          term = 1'b1;
        end else if (scell == opp_c) begin
          run_n = run + CW'(1);
          cx_n  = sx[CW-1:0];
          cy_n  = sy[CW-1:0];
        end else begin
          // Own piece brackets the run only if at least one opponent lies between.
          if ((scell == own_c) && (run != '0)) begin
            valids_n[dir]                           = 1'b1;
            end_points_n[int'(dir)*EPW +: EPW]      = {sy[CW-1:0], sx[CW-1:0]};
            flip_total_n                            = flip_total + FW'(run);
          end
          term = 1'b1;
        end
        if (term) begin
          if (dir == 3'd7) begin
            state_n = DONE;
          end else begin
            dir_n = dir + 3'd1;
            cx_n  = x_q;
            cy_n  = y_q;
            run_n = '0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      black_q    <= 1'b0;
      board_q    <= '0;
      dir        <= '0;
      cx         <= '0;
      cy         <= '0;
      run        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valids     <= '0;
      end_points <= '0;
      flip_total <= '0;
    end else begin
      state      <= state_n;
      x_q        <= x_n;
      y_q        <= y_n;
      black_q    <= black_n;
      board_q    <= board_n;
      dir        <= dir_n;
      cx         <= cx_n;
      cy         <= cy_n;
      run        <= run_n;
      busy       <= busy_n;
      done       <= done_n;
      valids     <= valids_n;
      end_points <= end_points_n;
      flip_total <= flip_total_n;
    end
  end

endmodule

// File: doc/reversi_move_scanner.md
REVERSI_MOVE_SCANNER -- requirements
Module: reversi_move_scanner

Interface
REQ-001 SHALL have parameter BOARD_DIM, default 8, meaning board side length; legal range 4..16, even.
REQ-002 SHALL have localparam CW = clog2(BOARD_DIM), meaning coordinate width, and EPW = 2*CW, meaning end-point field width.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have x, y  input  CW each  target column and row.
REQ-007 SHALL have player_black  input  1  mover colour: 1 = black, 0 = white.
REQ-008 SHALL have board  input  2*BOARD_DIM^2  cell (x,y) at bits [2*(y*BOARD_DIM+x) +: 2]; 00 = empty, 01 = black, 10 = white, 11 = empty.
REQ-009 SHALL have busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have done  output  1  one-cycle completion pulse.
REQ-011 SHALL have valids  output  8  per-direction capture flag.
REQ-012 SHALL have end_points  output  8*EPW  field d = {y,x} of the bracketing own piece, at [d*EPW +: EPW].
REQ-013 SHALL have flip_total  output  clog2(8*BOARD_DIM)  sum of captured pieces over valid directions.

Function
REQ-014 SHALL number directions d0..d7 = N(0,-1), NE(+1,-1), E(+1,0), SE(+1,+1), S(0,+1), SW(-1,+1), W(-1,0), NW(-1,-1), as (dx,dy); y grows downward.
REQ-015 SHALL implement FSM states IDLE, CHECK, SCAN, DONE.
REQ-016 SHALL, in IDLE with start=1 at cycle T, latch x, y, player_black and board, clear valids, end_points and flip_total, and enter CHECK at T+1.
REQ-017 SHALL, in CHECK, go to DONE if x or y >= BOARD_DIM or the target cell is non-empty; otherwise enter SCAN with d=0, cursor=target, run count=0.
REQ-018 SHALL, in SCAN, examine exactly one cell per clock: the cursor stepped once in direction d.
REQ-019 SHALL: stepped cell off-board or empty -> direction invalid, valid[d]=0, field d=0, terminate.
REQ-020 SHALL: opponent piece -> run count +1, cursor advances, continue next cycle.
REQ-021 SHALL: own piece -> valid[d]=1 if run count >= 1, set field d={y,x} of that cell, add run count to flip_total, terminate; if run count = 0, treat as invalid.
REQ-022 SHALL, on termination, advance to d+1 with cursor reset to target and count 0, and examine the first cell of d+1 in the next cycle; termination of d7 enters DONE.
REQ-023 SHALL assert done for exactly the one DONE cycle, then return to IDLE; latency = 2 + cells examined.
REQ-024 SHALL hold valids, end_points and flip_total stable from done until the next accepted start.
REQ-025 SHALL ignore start while busy; latched inputs SHALL NOT change mid-scan.
REQ-026 SHALL handle edge cells purely by bounds test, with no wrap-around across rows or columns.

Reset
REQ-027 SHALL, on resetn=0 at any clock edge including mid-scan, enter IDLE and clear busy, done, valids, end_points, flip_total and all internal counters.
REQ-028 SHALL accept start in the first cycle after resetn returns high.

Verification
REQ-029 Use BOARD_DIM=8 with the initial board W(3,3), W(4,4), B(3,4), B(4,3); black start at (3,2) at T -> done at T+11, valids=8'h10, field4={4,3}, flip_total=1.
REQ-030 Use the same board with black start at (3,3) -> done at T+2, valids=0, flip_total=0.
REQ-031 Use the same board with white start at (0,0) -> done at T+10, valids=0, end_points=0.
REQ-032 Use BOARD_DIM=4, row y=0 = B,W,W,empty, black start at (3,0) -> valids=8'h40, field6={0,0}, flip_total=2.
REQ-033 Pulse resetn low 3 cycles after start -> outputs zero, IDLE next cycle; a new start then completes normally.
REQ-034 Assert start during busy with different x,y -> ignored; results match the original request.
